// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: serializer state encoding and default baud divider.
package uart_tx_fifo_pkg;

    // 40 MHz system clock at 9600 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 4167;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with flush; head entry is visible on rd_data without a read latency.
module sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            // A pop on a flush edge has already handed its data downstream; the rest is discarded.
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // NOTE: storage has no reset; the level and pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (resetb && !clear && do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter for mprj_io[6]: write handshake into a FIFO, drained back-to-back by a
// fixed-divider serializer.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter  int FIFO_DEPTH   = 8,
    parameter  int DATA_W       = 8,
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    uart_state_e       state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic              tx_nxt, done_nxt, busy_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic [DATA_W-1:0] fifo_head;
    logic              push, pop, full, empty, baud_last;

    // No bypass: acceptance depends only on the registered fill level.
    assign wr_ready = ~full;
    assign push     = wr_valid & ~full;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock   (clock),
        .resetb  (resetb),
        .push    (push),
        .pop     (pop),
        .clear   (clear),
        .wr_data (wr_data),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        tx_nxt    = tx;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        baud_last = (baud_cnt == BAUD_LAST);

        case (state)
            IDLE: begin
                baud_nxt = '0;
                tx_nxt   = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_head;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    tx_nxt    = shift_reg[0];
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        shift_nxt = shift_reg >> 1;
                        bit_nxt   = bit_cnt + 1'b1;
                        tx_nxt    = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    done_nxt = 1'b1;
                    baud_nxt = '0;
                    // Chain straight into the next start bit so queued bytes leave with no idle gap.
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_head;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Mirror of the FIFO's occupancy update so tx_busy can be registered alongside it.
        level_nxt = clear ? '0 : fifo_level + LVL_W'(push) - LVL_W'(pop);
        busy_nxt  = (state_nxt != IDLE) | (level_nxt != '0);
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            tx        <= tx_nxt;
            tx_done   <= done_nxt;
            tx_busy   <= busy_nxt;
        end
    end

endmodule
